// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, two registered read ports, one write port, clear sweep
//   clk, rst_n (async, active low), clear_req (start sweep)
//   read_reg_1/2 -> read_data_1/2 one cycle later, read_valid when read issued outside a sweep
//   write_reg/write_data/regWrite: write port; busy: sweep in progress
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              regWrite,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_valid,
  output logic              busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state;
  logic [PW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction
  assign wr_ok = regWrite && in_range(write_reg) && !(ZERO_REG != 0 && write_reg == '0);
  // bypass only for legal writes, so a hardwired or out-of-range address never forwards
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if ((ZERO_REG != 0 && a == '0) || !in_range(a)) return '0;
    if (BYPASS != 0 && wr_ok && write_reg == a) return write_data;
    return mem[a[PW-1:0]];
  endfunction
  // storage has no reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_ok) mem[write_reg[PW-1:0]] <= write_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      ptr         <= '0;
      read_data_1 <= '0;
      read_data_2 <= '0;
      read_valid  <= 1'b0;
    end else if (state == CLEAR) begin
      read_data_1 <= '0;
      read_data_2 <= '0;
      read_valid  <= 1'b0;
      ptr         <= ptr + 1'b1;
      if (ptr == PW'(DEPTH - 1)) state <= IDLE;
    end else begin
      read_data_1 <= rd(read_reg_1);
      read_data_2 <= rd(read_reg_2);
      read_valid  <= 1'b1;
      if (clear_req) begin
        state <= CLEAR;
        ptr   <= '0;
      end
    end
  end
  assign busy = (state == CLEAR);
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param, DUT a (DEPTH 32, bypass) and DUT b (DEPTH 20, no bypass)
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic [4:0]  rr1 = '0, rr2 = '0, wr = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_v, a_busy, b_v, b_busy;
  typedef struct {logic chk; logic [31:0] d1; logic [31:0] d2;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_cmp = 0, n_bad = 0;
  int left_a = 0, left_b = 0;

  regfile_param dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .read_reg_1(rr1), .read_reg_2(rr2),
    .write_reg(wr), .write_data(wd), .regWrite(we), .read_data_1(a_rd1), .read_data_2(a_rd2),
    .read_valid(a_v), .busy(a_busy)
  );
  regfile_param #(.DEPTH(20), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .read_reg_1(rr1), .read_reg_2(rr2),
    .write_reg(wr), .write_data(wd), .regWrite(we), .read_data_1(b_rd1), .read_data_2(b_rd2),
    .read_valid(b_v), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_v) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_valid: got read_valid=1 expected no read pending");
      end else begin
        ea = qa.pop_front();
        if (ea.chk) begin
          chk("a_rd1", a_rd1, ea.d1);
          chk("a_rd2", a_rd2, ea.d2);
        end
      end
    end
    if (b_v) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_valid: got read_valid=1 expected no read pending");
      end else begin
        eb = qb.pop_front();
        if (eb.chk) begin
          chk("b_rd1", b_rd1, eb.d1);
          chk("b_rd2", b_rd2, eb.d2);
        end
      end
    end
  end

  task automatic set(input logic e, input logic [4:0] w, input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    we = e; wr = w; wd = d; rr1 = r1; rr2 = r2;
  endtask

  // one clock edge; a read is expected only when the bench's sweep counter says the DUT is idle
  task automatic tick(input logic ca, input logic [31:0] a1, input logic [31:0] a2,
                      input logic cb, input logic [31:0] b1, input logic [31:0] b2);
    if (rst_n) begin
      if (left_a == 0) begin
        qa.push_back('{ca, a1, a2});
        if (clear_req) left_a = 32;
      end else left_a--;
      if (left_b == 0) begin
        qb.push_back('{cb, b1, b2});
        if (clear_req) left_b = 20;
      end else left_b--;
    end
    @(posedge clk); #1;
    chk("a_busy", {31'd0, a_busy}, {31'd0, left_a != 0});
    chk("b_busy", {31'd0, b_busy}, {31'd0, left_b != 0});
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; clear_req = 1'b0; we = 1'b0;
    #1;
    chk("rst_a_rd1", a_rd1, 32'h0);
    chk("rst_a_rd2", a_rd2, 32'h0);
    chk("rst_a_valid", {31'd0, a_v}, 32'h0);
    chk("rst_a_busy", {31'd0, a_busy}, 32'h1);
    chk("rst_b_rd1", b_rd1, 32'h0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    left_a = 32;
    left_b = 20;
  endtask

  task automatic idle_zero(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 1, 0, 0);
  endtask

  initial begin
    do_reset();
    set(0, 0, 0, 0, 0);
    idle_zero(32);
    for (int i = 0; i < 32; i++) begin
      set(0, 0, 0, 5'(i), 5'(31 - i));
      tick(1, 0, 0, 1, 0, 0);
    end
    set(1, 5, 32'hDEADBEEF, 0, 0);  tick(1, 0, 0, 1, 0, 0);
    set(0, 0, 0, 5, 0);             tick(1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0);
    set(1, 0, 32'h1234, 0, 5);      tick(1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
    set(0, 0, 0, 0, 0);             tick(1, 0, 0, 1, 0, 0);
    set(1, 7, 32'h11, 0, 0);        tick(1, 0, 0, 1, 0, 0);
    set(1, 7, 32'hA5A5A5A5, 7, 7);  tick(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 32'h11, 32'h11);
    set(0, 0, 0, 7, 7);             tick(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    set(1, 25, 32'hFF, 25, 19);     tick(1, 32'hFF, 0, 1, 0, 0);
    set(1, 19, 32'h1919, 25, 19);   tick(1, 32'hFF, 32'h1919, 1, 0, 0);
    set(0, 0, 0, 25, 19);           tick(1, 32'hFF, 32'h1919, 1, 0, 32'h1919);
    set(1, 3, 32'h55, 3, 0);        tick(1, 32'h55, 0, 1, 0, 0);
    set(0, 0, 0, 3, 5);             tick(1, 32'h55, 32'hDEADBEEF, 1, 32'h55, 32'hDEADBEEF);
    clear_req = 1'b1;
    set(1, 4, 32'h66, 4, 3);        tick(1, 32'h66, 32'h55, 1, 0, 32'h55);
    for (int i = 0; i < 40; i++) begin
      clear_req = (i == 3);
      set(i == 15, 9, 32'h99, 3, 4);
      tick(1, 0, 0, 1, 0, 0);
    end
    clear_req = 1'b0;
    set(0, 0, 0, 9, 5);             tick(1, 0, 0, 1, 0, 0);
    set(0, 0, 0, 7, 25);            tick(1, 0, 0, 1, 0, 0);
    set(1, 6, 32'hCAFE, 0, 0);      tick(1, 0, 0, 1, 0, 0);
    set(0, 0, 0, 6, 7);             tick(1, 32'hCAFE, 0, 1, 32'hCAFE, 0);
    do_reset();
    set(0, 0, 0, 0, 0);
    idle_zero(32);
    clear_req = 1'b1;               tick(1, 0, 0, 1, 0, 0);
    clear_req = 1'b0;
    idle_zero(10);
    do_reset();
    set(0, 0, 0, 0, 0);
    idle_zero(32);
    set(0, 0, 0, 6, 19);            tick(1, 0, 0, 1, 0, 0);
    set(0, 0, 0, 0, 0);             tick(1, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    chk("a_queue_left", qa.size(), 0);
    chk("b_queue_left", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Next-generation register file for the MIPS datapath: parametrised width/depth, two synchronous read ports, one write port.
- Adds three behaviours: optional hardwired-zero register 0, optional write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset or on request.
- Sits between decode (read addresses) and writeback (write port). Reads have 1-cycle latency and align with a registered ID/EX boundary.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width
DEPTH, 32, number of entries; must satisfy 2 <= DEPTH <= 2^ADDR_W
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear_req  in  1  pulse: start a full clear sweep
read_reg_1  in  ADDR_W  read port 1 address
read_reg_2  in  ADDR_W  read port 2 address
write_reg  in  ADDR_W  write address
write_data  in  DATA_W  write data
regWrite  in  1  write enable
read_data_1  out  DATA_W  registered read data, port 1
read_data_2  out  DATA_W  registered read data, port 2
read_valid  out  1  read_data_* correspond to reads issued while not busy
busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst_n=0, asynchronous): read_data_1=0, read_data_2=0, read_valid=0, busy=1, state=CLEAR, clear pointer=0. Storage contents are not reset directly; the sweep zeroes them.
- State machine has two states, IDLE and CLEAR.
- CLEAR:
  - Each rising edge writes 0 to entry[ptr], then increments ptr.
  - At the edge where ptr==DEPTH-1, writes the last entry and goes to IDLE. busy is low from that edge onward.
  - A sweep therefore takes exactly DEPTH cycles after reset release.
  - regWrite is ignored during CLEAR; the write is dropped, not queued.
  - clear_req is ignored during CLEAR; no restart.
  - Reads issued in CLEAR register read_data_*=0 and read_valid=0.
- IDLE:
  - clear_req=1 at an edge sets state=CLEAR, ptr=0, busy=1.
  - A regWrite at that same edge is still performed, then erased by the sweep.
- Write: in IDLE, at the rising edge with regWrite=1, entry[write_reg] <= write_data. The write is dropped if write_reg >= DEPTH, or if ZERO_REG=1 and write_reg==0.
- Read timing: at each rising edge in IDLE, read_data_x <= value for read_reg_x, and read_valid <= 1. Data appears one cycle after the address is presented.
- Read value rules, evaluated per port in priority order:
  1. ZERO_REG=1 and addr==0 gives 0.
  2. addr >= DEPTH gives 0.
  3. BYPASS=1, regWrite=1, and write_reg==addr (and the write is legal) gives write_data.
  4. Otherwise gives the stored entry[addr], which is the pre-write value when BYPASS=0.
- Both ports may read the same address and may both hit the bypass in the same cycle.
- Reset asserted mid-sweep or mid-operation: immediate return to reset values; the sweep restarts from ptr=0 after release.
- No X may propagate to read_data_* after the first sweep completes. Every entry has been written with 0 by then.

Test Plan:
- Reset, DEPTH=32: release rst_n -> busy=1 for exactly 32 cycles, then 0. Reading every address 0..31 afterwards returns 0 with read_valid=1.
- In IDLE, write 0xDEADBEEF to reg 5, read reg 5 on port 1 next cycle -> read_data_1=0xDEADBEEF one cycle after the address is applied. Write 0x1234 to reg 0 with ZERO_REG=1, then read reg 0 -> 0.
- Same-edge write of 0xA5A5A5A5 to reg 7 with read_reg_1=read_reg_2=7, prior value 0x11 -> both ports show 0xA5A5A5A5 when BYPASS=1, and 0x11 when BYPASS=0.
- Write reg 3=0x55, pulse clear_req with a simultaneous write to reg 4=0x66 -> busy=1 for 32 cycles. A regWrite to reg 9 during the sweep is dropped. After busy falls, regs 3, 4 and 9 read 0.
- DEPTH=20, ADDR_W=5: write 0xFF to reg 25, read reg 25 -> 0. Reg 19 write/read works normally.
- Assert rst_n=0 at cycle 10 of a sweep -> outputs 0 immediately. After release, busy stays high for a full DEPTH cycles from ptr=0.
